// File: rtl/dram_initiator_pkg.sv
// Shared definitions for the DRAM initiator: FSM state encoding and
// default access timing (all in clk200 cycles).
package dram_initiator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    RAS,
    COL,
    CAS,
    PRE
  } state_t;

  localparam int T_RCD_DEFAULT = 4;
  localparam int T_CAS_DEFAULT = 6;
  localparam int T_RP_DEFAULT  = 6;

  // Down-counter width; holds timing values up to 15
  localparam int CNT_W = 4;

endpackage

// File: rtl/dram_initiator.sv
// Single-access asynchronous DRAM initiator: turns a toggle req/ack handshake
// into a ROW/RAS/COL/CAS/PRE strobe sequence on the DR_* pins.
module dram_initiator
  import dram_initiator_pkg::*;
#(
  parameter int T_RCD = T_RCD_DEFAULT,
  parameter int T_CAS = T_CAS_DEFAULT,
  parameter int T_RP  = T_RP_DEFAULT
) (
  input  logic        clk200,
  input  logic        reset_n,
  input  logic        req,
  output logic        ack,
  input  logic        read,
  input  logic [18:0] address,
  input  logic        lb,
  input  logic        ub,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        DR_WE_n,
  output logic        DR_RAS0_n,
  output logic        DR_RAS1_n,
  output logic        DR_CASL_n,
  output logic        DR_CASU_n,
  output logic [8:0]  DR_A,
  inout  tri   [15:0] DR_D
);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_zero;
  logic               pending;
  logic               any_lane;
  logic               read_q;
  logic [18:0]        addr_q;
  logic               lb_q;
  logic               ub_q;
  logic [15:0]        wdata_q;
  logic [8:0]         row_addr;
  logic [8:0]         col_addr;
  logic               drive_lo;
  logic               drive_hi;

  assign cnt_zero = (cnt == '0);
  assign pending  = (req != ack);
  assign any_lane = lb_q | ub_q;
  assign row_addr = {addr_q[16], addr_q[15:8]};
  assign col_addr = {addr_q[17], addr_q[7:0]};

  always_ff @(posedge clk200 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (pending) next_state = ROW;
      ROW:  next_state = any_lane ? RAS : IDLE;
      RAS:  if (cnt_zero) next_state = COL;
      COL:  next_state = CAS;
      CAS:  if (cnt_zero) next_state = PRE;
      PRE:  if (cnt_zero) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch, shared timing counter, handshake and read capture
  always_ff @(posedge clk200 or negedge reset_n) begin
    if (!reset_n) begin
      read_q  <= 1'b0;
      addr_q  <= '0;
      lb_q    <= 1'b0;
      ub_q    <= 1'b0;
      wdata_q <= '0;
      cnt     <= '0;
      ack     <= 1'b0;
      rdata   <= '0;
    end else begin
      if (state == IDLE && pending) begin
        read_q  <= read;
        addr_q  <= address;
        lb_q    <= lb;
        ub_q    <= ub;
        wdata_q <= wdata;
      end

      if (state == ROW)
        cnt <= CNT_W'(T_RCD - 1);
      else if (state == COL)
        cnt <= CNT_W'(T_CAS - 1);
      else if (state == CAS && cnt_zero)
        cnt <= CNT_W'(T_RP - 1);
      else if (!cnt_zero && (state == RAS || state == CAS || state == PRE))
        cnt <= cnt - 1'b1;

      // A request with no byte lanes enabled completes straight from ROW
      if ((state == ROW && !any_lane) || (state == PRE && cnt_zero))
        ack <= ~ack;

      if (state == CAS && cnt_zero && read_q) begin
        if (lb_q) rdata[7:0]  <= DR_D[7:0];
        if (ub_q) rdata[15:8] <= DR_D[15:8];
      end
    end
  end

  always_comb begin
    DR_WE_n   = 1'b1;
    DR_RAS0_n = 1'b1;
    DR_RAS1_n = 1'b1;
    DR_CASL_n = 1'b1;
    DR_CASU_n = 1'b1;
    DR_A      = '0;
    drive_lo  = 1'b0;
    drive_hi  = 1'b0;
    case (state)
      ROW: begin
        DR_A    = row_addr;
        DR_WE_n = read_q | ~any_lane;
      end
      RAS: begin
        DR_A      = row_addr;
        DR_WE_n   = read_q;
        DR_RAS0_n = ~addr_q[18];
        DR_RAS1_n = addr_q[18];
      end
      COL, CAS: begin
        DR_A      = col_addr;
        DR_WE_n   = read_q;
        DR_RAS0_n = ~addr_q[18];
        DR_RAS1_n = addr_q[18];
        drive_lo  = ~read_q & lb_q;
        drive_hi  = ~read_q & ub_q;
        if (state == CAS) begin
          DR_CASL_n = ~lb_q;
          DR_CASU_n = ~ub_q;
        end
      end
      default: ;
    endcase
  end

  assign DR_D[7:0]  = drive_lo ? wdata_q[7:0]  : 8'hzz;
  assign DR_D[15:8] = drive_hi ? wdata_q[15:8] : 8'hzz;

endmodule
